// File: rtl/sram_req_ctrl_pkg.sv
// sram_req_ctrl_pkg: shared sizes for the sky130 1rw1r 32x256 SRAM initiator, plus the
// per-channel response-credit helper used by the controller top.
//   SRAM_ADDR_W      word address width of the macro
//   SRAM_DATA_W      word width of the macro
//   SRAM_NUM_WMASKS  byte-enable width (SRAM_DATA_W / 8)
package sram_req_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W     = 8;
  localparam int unsigned SRAM_DATA_W     = 32;
  localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_W / 8;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // A read may be accepted only while the response slots it could land in are not all
  // claimed. A response popping this cycle frees its slot for a same-cycle accept.
  function automatic logic credit_ok(input logic        inflight,
                                     input int unsigned count,
                                     input logic        pop,
                                     input int unsigned depth);
    int unsigned occ;
    occ = count + 32'(inflight) - 32'(pop);
    return occ < depth;
  endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// sram_req_ctrl_if: request/response handshakes between user bus logic and the SRAM
// initiator.
//   Channel A: a_valid/a_ready, a_we, a_wmask, a_addr, a_wdata (read/write request)
//              a_rsp_valid/a_rsp_ready, a_rsp_data (read response)
//   Channel B: b_valid/b_ready, b_addr (read request)
//              b_rsp_valid/b_rsp_ready, b_rsp_data (read response)
// Modports: master = bus logic issuing requests, slave = the controller.
interface sram_req_ctrl_if
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
  parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS
) ();

  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [NUM_WMASKS-1:0] a_wmask;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rsp_valid;
  logic                  a_rsp_ready;
  logic [DATA_WIDTH-1:0] a_rsp_data;

  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_rsp_valid;
  logic                  b_rsp_ready;
  logic [DATA_WIDTH-1:0] b_rsp_data;

  modport master (
    output a_valid, a_we, a_wmask, a_addr, a_wdata, a_rsp_ready,
    output b_valid, b_addr, b_rsp_ready,
    input  a_ready, a_rsp_valid, a_rsp_data,
    input  b_ready, b_rsp_valid, b_rsp_data
  );

  modport slave (
    input  a_valid, a_we, a_wmask, a_addr, a_wdata, a_rsp_ready,
    input  b_valid, b_addr, b_rsp_ready,
    output a_ready, a_rsp_valid, a_rsp_data,
    output b_ready, b_rsp_valid, b_rsp_data
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: show-ahead response buffer, one per controller channel.
//   clk_i    clock
//   rst_i    synchronous active-high reset; empties the buffer
//   push_i   write data_i this edge (caller guarantees space via credits)
//   data_i   word to store
//   pop_i    consume the head entry this edge (ignored when empty)
//   valid_o  buffer non-empty; data_o is the head entry
//   data_o   head entry, zero when empty
//   count_o  number of stored entries
// Push and pop on the same edge both take effect, including when full.
module sram_rsp_fifo
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [Width-1:0]            data_i,
  input  logic                        pop_i,
  output logic                        valid_o,
  output logic [Width-1:0]            data_o,
  output logic [cnt_width(Depth)-1:0] count_o
);

  localparam int unsigned CntW = cnt_width(Depth);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign pop_en  = pop_i & (count_q != '0);
  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CntW'(push_i) - CntW'(pop_en);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: initiator side of the sky130 1rw1r 32x256 SRAM macro.
//   wb_clk_i     clock, shared with the macro clk0/clk1
//   wb_rst_i     synchronous active-high reset; drops in-flight and buffered responses
//   bus          sram_req_ctrl_if.slave: channel A read/write, channel B read-only
//   sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, sram_dout0   macro port 0
//   sram_csb1, sram_addr1, sram_dout1                                      macro port 1
// Macro pins are combinational from the accepting handshake; the macro samples at the
// acceptance edge N and launches dout on the following negedge, which is captured into
// the channel's response FIFO at edge N+1.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
  parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  sram_req_ctrl_if.slave        bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int unsigned CntW = cnt_width(RSP_DEPTH);

  logic            a_inflight_q, a_inflight_d;
  logic            b_inflight_q, b_inflight_d;
  logic [CntW-1:0] a_count, b_count;
  logic            a_rsp_valid, b_rsp_valid;
  logic [DATA_WIDTH-1:0] a_rsp_data, b_rsp_data;
  logic            a_fire, b_fire, a_pop, b_pop;
  logic            a_credit, b_credit, collide;

  assign a_pop = a_rsp_valid & bus.a_rsp_ready;
  assign b_pop = b_rsp_valid & bus.b_rsp_ready;

  assign a_credit = credit_ok(a_inflight_q, 32'(a_count), a_pop, RSP_DEPTH);
  assign b_credit = credit_ok(b_inflight_q, 32'(b_count), b_pop, RSP_DEPTH);

  always_comb begin
    bus.a_ready = ~wb_rst_i & (bus.a_we | a_credit);
    a_fire      = bus.a_valid & bus.a_ready;
    // A write and a B read to the same word on the same edge would race inside the
    // macro; A wins and B retries next cycle.
    collide     = a_fire & bus.a_we & (bus.a_addr == bus.b_addr);
    bus.b_ready = ~wb_rst_i & b_credit & ~collide;
    b_fire      = bus.b_valid & bus.b_ready;

    a_inflight_d = a_fire & ~bus.a_we;
    b_inflight_d = b_fire;

    bus.a_rsp_valid = a_rsp_valid;
    bus.a_rsp_data  = a_rsp_data;
    bus.b_rsp_valid = b_rsp_valid;
    bus.b_rsp_data  = b_rsp_data;
  end

  // Write enable is held inactive whenever the port is not selected.
  assign sram_csb0   = ~a_fire;
  assign sram_web0   = ~(a_fire & bus.a_we);
  assign sram_wmask0 = bus.a_wmask;
  assign sram_addr0  = bus.a_addr;
  assign sram_din0   = bus.a_wdata;
  assign sram_csb1   = ~b_fire;
  assign sram_addr1  = bus.b_addr;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_inflight_q <= 1'b0;
      b_inflight_q <= 1'b0;
    end else begin
      a_inflight_q <= a_inflight_d;
      b_inflight_q <= b_inflight_d;
    end
  end

  sram_rsp_fifo #(
    .Depth (RSP_DEPTH),
    .Width (DATA_WIDTH)
  ) u_a_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (a_inflight_q),
    .data_i  (sram_dout0),
    .pop_i   (a_pop),
    .valid_o (a_rsp_valid),
    .data_o  (a_rsp_data),
    .count_o (a_count)
  );

  sram_rsp_fifo #(
    .Depth (RSP_DEPTH),
    .Width (DATA_WIDTH)
  ) u_b_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (b_inflight_q),
    .data_i  (sram_dout1),
    .pop_i   (b_pop),
    .valid_o (b_rsp_valid),
    .data_o  (b_rsp_data),
    .count_o (b_count)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed bench for sram_req_ctrl with a behavioural 1rw1r macro model
// (posedge sample, negedge-launched dout, preloaded contents).
module tb_sram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_req_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4)) bus ();

  sram_req_ctrl #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .NUM_WMASKS (4),
    .RSP_DEPTH  (2)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .bus         (bus),
    .sram_csb0   (csb0),
    .sram_web0   (web0),
    .sram_wmask0 (wmask0),
    .sram_addr0  (addr0),
    .sram_din0   (din0),
    .sram_dout0  (dout0),
    .sram_csb1   (csb1),
    .sram_addr1  (addr1),
    .sram_dout1  (dout1)
  );

  function automatic logic [31:0] pre(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5A, b + 8'h33};
  endfunction

  // Macro model: contents preloaded on the first edge.
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;
  logic        rd0_pend, rd1_pend;
  logic [7:0]  rd0_addr, rd1_addr;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pre(i);
      mem_init <= 1'b1;
    end else if (!csb0 && !web0) begin
      for (int k = 0; k < 4; k++)
        if (wmask0[k]) mem[addr0][k*8 +: 8] <= din0[k*8 +: 8];
    end
    rd0_pend <= !csb0 && web0;
    rd0_addr <= addr0;
    rd1_pend <= !csb1;
    rd1_addr <= addr1;
  end

  always @(negedge clk) begin
    if (rd0_pend) dout0 <= mem[rd0_addr];
    if (rd1_pend) dout1 <= mem[rd1_addr];
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an A request at the negedge, expect it ready, let the posedge accept it.
  task automatic a_req(input logic we, input logic [7:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input string tag);
    @(negedge clk);
    bus.a_valid = 1'b1;
    bus.a_we    = we;
    bus.a_addr  = addr;
    bus.a_wdata = data;
    bus.a_wmask = mask;
    #1;
    check1(tag, bus.a_ready, 1'b1);
    @(posedge clk);
  endtask

  // A read with exact-latency response check; the response is popped before returning.
  task automatic a_read_check(input logic [7:0] addr, input logic [31:0] exp,
                              input string tag);
    a_req(1'b0, addr, 32'h0, 4'h0, {tag, "_rdy"});
    @(negedge clk);
    bus.a_valid = 1'b0;
    #1;
    check1({tag, "_lat"}, bus.a_rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    check1({tag, "_vld"}, bus.a_rsp_valid, 1'b1);
    check32({tag, "_data"}, bus.a_rsp_data, exp);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.a_valid     = 1'b0;
    bus.a_we        = 1'b0;
    bus.a_addr      = '0;
    bus.a_wdata     = '0;
    bus.a_wmask     = '0;
    bus.a_rsp_ready = 1'b1;
    bus.b_valid     = 1'b0;
    bus.b_addr      = '0;
    bus.b_rsp_ready = 1'b1;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check1("rst_a_ready", bus.a_ready, 1'b0);
    check1("rst_b_ready", bus.b_ready, 1'b0);
    check1("rst_a_rsp_valid", bus.a_rsp_valid, 1'b0);
    check1("rst_b_rsp_valid", bus.b_rsp_valid, 1'b0);
    check32("rst_a_rsp_data", bus.a_rsp_data, 32'h0);
    check32("rst_b_rsp_data", bus.b_rsp_data, 32'h0);
    check1("rst_csb0", csb0, 1'b1);
    check1("rst_csb1", csb1, 1'b1);
    check1("rst_web0", web0, 1'b1);
    rst = 1'b0;

    // B streams every address back to back: one accept per cycle, no bubbles
    for (int i = 0; i < 258; i++) begin
      @(negedge clk);
      if (i < 256) begin
        bus.b_valid = 1'b1;
        bus.b_addr  = 8'(i);
      end else begin
        bus.b_valid = 1'b0;
      end
      #1;
      if (i < 256) check1("t5_b_ready", bus.b_ready, 1'b1);
      if (i >= 2) begin
        check1("t5_b_rsp_valid", bus.b_rsp_valid, 1'b1);
        check32("t5_b_rsp_data", bus.b_rsp_data, pre(i - 2));
      end
    end
    @(posedge clk);
    #1;
    check1("t5_b_drained", bus.b_rsp_valid, 1'b0);

    // Full-word write then read back; pin mapping during the write
    @(negedge clk);
    bus.a_valid = 1'b1;
    bus.a_we    = 1'b1;
    bus.a_addr  = 8'h10;
    bus.a_wdata = 32'hDEADBEEF;
    bus.a_wmask = 4'hF;
    #1;
    check1("t1_wr_rdy", bus.a_ready, 1'b1);
    check1("t1_wr_csb0", csb0, 1'b0);
    check1("t1_wr_web0", web0, 1'b0);
    @(posedge clk);
    a_read_check(8'h10, 32'hDEADBEEF, "t1_rd");

    // Partial write: bytes 0 and 2 only
    a_req(1'b1, 8'h10, 32'h11223344, 4'b0101, "t2_wr_rdy");
    a_read_check(8'h10, 32'hDE22BE44, "t2_rd");

    // A write and B read to the same word collide; B retries next cycle
    @(negedge clk);
    bus.a_valid = 1'b1;
    bus.a_we    = 1'b1;
    bus.a_addr  = 8'h20;
    bus.a_wdata = 32'hCAFEF00D;
    bus.a_wmask = 4'hF;
    bus.b_valid = 1'b1;
    bus.b_addr  = 8'h20;
    #1;
    check1("t3_a_ready", bus.a_ready, 1'b1);
    check1("t3_b_blocked", bus.b_ready, 1'b0);
    check1("t3_csb1_idle", csb1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.a_valid = 1'b0;
    #1;
    check1("t3_b_retry", bus.b_ready, 1'b1);
    check1("t3_csb1_sel", csb1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.b_valid = 1'b0;
    #1;
    check1("t3_b_lat", bus.b_rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    check1("t3_b_vld", bus.b_rsp_valid, 1'b1);
    check32("t3_b_data", bus.b_rsp_data, 32'hCAFEF00D);

    // A read and B read to the same word both proceed
    @(negedge clk);
    bus.a_valid = 1'b1;
    bus.a_we    = 1'b0;
    bus.a_addr  = 8'h20;
    bus.b_valid = 1'b1;
    bus.b_addr  = 8'h20;
    #1;
    check1("t3r_a_ready", bus.a_ready, 1'b1);
    check1("t3r_b_ready", bus.b_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(posedge clk);
    #1;
    check32("t3r_a_data", bus.a_rsp_data, 32'hCAFEF00D);
    check32("t3r_b_data", bus.b_rsp_data, 32'hCAFEF00D);
    @(posedge clk);

    // Backpressure: two reads fill the credits, third waits until a response drains
    @(negedge clk);
    bus.a_rsp_ready = 1'b0;
    bus.a_valid     = 1'b1;
    bus.a_we        = 1'b0;
    bus.a_addr      = 8'd1;
    #1;
    check1("t4_rdy1", bus.a_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.a_addr = 8'd2;
    #1;
    check1("t4_rdy2", bus.a_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.a_addr = 8'd3;
    #1;
    check1("t4_full1", bus.a_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check1("t4_full2", bus.a_ready, 1'b0);
    check1("t4_hold_vld", bus.a_rsp_valid, 1'b1);
    check32("t4_hold_data", bus.a_rsp_data, pre(1));
    @(posedge clk);
    @(negedge clk);
    bus.a_rsp_ready = 1'b1;
    #1;
    check1("t4_release_rdy", bus.a_ready, 1'b1);
    check32("t4_d1", bus.a_rsp_data, pre(1));
    @(posedge clk);
    @(negedge clk);
    bus.a_valid = 1'b0;
    #1;
    check1("t4_d2_vld", bus.a_rsp_valid, 1'b1);
    check32("t4_d2", bus.a_rsp_data, pre(2));
    @(posedge clk);
    #1;
    check1("t4_d3_vld", bus.a_rsp_valid, 1'b1);
    check32("t4_d3", bus.a_rsp_data, pre(3));
    @(posedge clk);
    #1;
    check1("t4_empty", bus.a_rsp_valid, 1'b0);

    // Reset with two A reads outstanding drops both
    @(negedge clk);
    bus.a_rsp_ready = 1'b0;
    bus.a_valid     = 1'b1;
    bus.a_we        = 1'b0;
    bus.a_addr      = 8'd4;
    @(posedge clk);
    @(negedge clk);
    bus.a_addr = 8'd5;
    @(posedge clk);
    @(negedge clk);
    rst         = 1'b1;
    bus.a_addr  = 8'd6;
    bus.b_valid = 1'b1;
    bus.b_addr  = 8'd7;
    #1;
    check1("t6_csb0_in_rst", csb0, 1'b1);
    check1("t6_csb1_in_rst", csb1, 1'b1);
    check1("t6_a_ready_in_rst", bus.a_ready, 1'b0);
    @(posedge clk);
    #1;
    check1("t6_a_rsp_valid", bus.a_rsp_valid, 1'b0);
    check32("t6_a_rsp_data", bus.a_rsp_data, 32'h0);
    check1("t6_b_rsp_valid", bus.b_rsp_valid, 1'b0);
    @(negedge clk);
    rst             = 1'b0;
    bus.a_valid     = 1'b0;
    bus.b_valid     = 1'b0;
    bus.a_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check1("t6_quiet_a", bus.a_rsp_valid, 1'b0);
      check1("t6_quiet_b", bus.b_rsp_valid, 1'b0);
    end
    a_read_check(8'd6, pre(6), "t6_new");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
